sdspi_burst: RTL and testbench
==============================

Name: sdspi_burst

Overview:
- Parametrised successor to the single-byte SD-card SPI master.
- Runs one SPI mode-0 link (CPOL=0, CPHA=0) with configurable word width and SCLK divisors.
- Supports multi-word burst transfers with a per-word TX/RX handshake and a busy flag.
- Sits between the RK8E disk controller sequencer and the SD card pins, and serves SD commands and 512-byte data blocks.

Parameters:
- DATA_W, 8: bits per SPI word; shifted MSB first; legal values 8, 16, 32.
- SLOW_DIV, 100: clk cycles per SCLK half-period in slow mode (≤400 kHz SD init); must be ≥2.
- FAST_DIV, 2: clk cycles per SCLK half-period in fast mode; must be ≥1.
- CNT_W, 10: width of the burst word count.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- spiOP  in  spiOP_t  command: spiNOP, spiCSL, spiCSH, spiSLOW, spiFAST, spiTR (+ spiCRCCLR with the feature)
- spiCNT  in  CNT_W  words in the burst; sampled with spiTR; 0 is treated as 1
- spiTXD  in  DATA_W  transmit word
- spiTXACK  out  1  one-cycle pulse: spiTXD latched; the caller may present the next word
- spiRXD  out  DATA_W  last received word; held until the next word completes
- spiRXV  out  1  one-cycle pulse: spiRXD updated
- spiDONE  out  1  one-cycle pulse: burst complete
- spiBUSY  out  1  high from spiTR acceptance until the spiDONE cycle, inclusive
- spiCS  out  1  chip select, active-low
- spiSCLK  out  1  SPI clock
- spiMOSI  out  1  SPI data out
- spiMISO  in  1  SPI data in

Behaviour:
- Reset values: spiCS=1, spiSCLK=0, spiMOSI=1, spiRXD=0, spiTXACK=0, spiRXV=0, spiDONE=0, spiBUSY=0.
- After reset, speed is slow and all counters are 0.
- Reset asserted mid-transfer aborts immediately to these values; no spiDONE is produced.
- FSM states: IDLE, LOAD, HIGH, LOW, WEND.
- IDLE command handling: spiCSL → spiCS=0 next cycle; spiCSH → spiCS=1; spiSLOW/spiFAST → select divisor; spiNOP → no change.
- While spiBUSY=1, every op is ignored, including CS and speed changes.
- spiTR in IDLE at edge T: latch spiTXD and spiCNT.
  - At T+1: spiBUSY=1, spiTXACK=1, spiMOSI = bit DATA_W-1; state LOW.
- The divider counter reloads with the active divisor.
  - LOW: SCLK=0 for DIV cycles, then SCLK rises; state HIGH.
  - HIGH: MISO is sampled into the RX shifter on the rising-edge cycle; SCLK stays 1 for DIV cycles, then falls.
  - On the fall: if bits remain, MOSI presents the next bit and the state returns to LOW; otherwise go to WEND.
- WEND, one cycle:
  - spiRXD ← shifter, spiRXV=1, word count decrements.
  - If words remain: latch spiTXD and pulse spiTXACK in the same cycle; MOSI = new MSB; state LOW.
  - If not: spiDONE=1, spiMOSI=1, spiBUSY drops the following cycle; state IDLE.
- Per-word length is 2·DIV·DATA_W + 1 clk cycles; SCLK has no gap between words except the WEND cycle.
- The divisor is frozen for the whole burst.
- CS is never changed by spiTR; the caller brackets bursts with spiCSL/spiCSH.
- spiTR with spiCS=1 is still executed (SD init sends 80 clocks with CS high).
- The word counter is CNT_W bits and does not wrap: the last word is detected at count 1.

Optional Feature:
- Macro SDSPI_CRC16_EN.
- When defined:
  - Adds output spiCRC (16 bits) and op spiCRCCLR.
  - CRC-16-CCITT (poly 0x1021, init 0x0000) is updated bit-serially on every MOSI bit shifted out, on the rising-SCLK cycle.
  - spiCRCCLR in IDLE zeroes the CRC next cycle.
  - spiCRC is stable from spiDONE until the next spiTR.
- When not defined: no spiCRC port, spiCRCCLR is absent from spiOP_t, and there is no CRC logic.

Decomposition:
- Package sdspi_types holds: spiOP_t enum (spiCRCCLR conditional), state enum, CRC polynomial constant.
- Package sd_types holds sdBYTE_t (existing).
- One sub-module, sdspi_clkdiv: the divider counter with divisor select, load and terminal-count pulse.

Test Plan:
- Reset, spiFAST, spiCSL, spiTR with spiCNT=1, spiTXD=8'h55, MISO tied to the MOSI loopback → spiMOSI shows 0,1,0,1,0,1,0,1 on rising edges; spiRXD=8'h55; one spiRXV and one spiDONE; spiCS=0 throughout.
- Default slow mode, spiTR, one word 8'hAA → SCLK half-period = 100 clk; total busy = 1601 cycles plus 1; spiDONE exactly once.
- Fast burst, spiCNT=3, TX words 8'h01, 8'h02, 8'h03 updated after each spiTXACK, MISO driving 8'hF0/8'h0F/8'hFF → three spiTXACK, three spiRXV with those values in order, one spiDONE after the third.
- spiCSH and spiSLOW issued while spiBUSY → no change to spiCS or divisor; after spiDONE, spiCSH → spiCS=1 next cycle.
- rst driven low mid-word during a 4-word burst → all outputs at reset values asynchronously; no spiDONE; a subsequent spiTR works normally.
- With SDSPI_CRC16_EN: spiCRCCLR, then send ASCII "123456789" as 9 words → spiCRC=16'h31C3.

Source files
------------

// File: rtl/sdspi_burst_pkg.sv
// Shared types for the SD-card SPI burst master: command and state enums, CRC constant.
// Defining SDSPI_CRC16_EN adds the spiCRCCLR command and the CRC step helper.
package sd_types;
    typedef logic [7:0] sdBYTE_t;
endpackage

package sdspi_types;
    typedef enum logic [2:0] {
        spiNOP,
        spiCSL,
        spiCSH,
        spiSLOW,
        spiFAST,
        spiTR
`ifdef SDSPI_CRC16_EN
        ,
        spiCRCCLR
`endif
    } spiOP_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HIGH,
        LOW,
        WEND
    } state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;

`ifdef SDSPI_CRC16_EN
    // One bit of CRC-16-CCITT, MSB-first, matching the order bits leave on MOSI.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction
`endif
endpackage

// File: rtl/sdspi_burst_clkdiv.sv
// SCLK half-period divider: reloads with the selected divisor and flags terminal count.
// tc is high while the counter sits at zero, i.e. on the last cycle of a half-period.
module sdspi_clkdiv #(
    parameter int SLOW_DIV = 100,
    parameter int FAST_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic fast,
    input  logic load,
    input  logic en,
    output logic tc
);
    localparam int MAX_DIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int W       = ($clog2(MAX_DIV) < 1) ? 1 : $clog2(MAX_DIV);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= fast ? W'(FAST_DIV - 1) : W'(SLOW_DIV - 1);
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);
endmodule

// File: rtl/sdspi_burst.sv
// SPI mode-0 burst master for the SD card, with per-word TX/RX handshake and busy flag.
// Defining SDSPI_CRC16_EN adds the spiCRC output, tracking CRC-16-CCITT over MOSI bits.
module sdspi_burst
    import sdspi_types::*;
#(
    parameter int DATA_W   = 8,
    parameter int SLOW_DIV = 100,
    parameter int FAST_DIV = 2,
    parameter int CNT_W    = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  spiOP_t            spiOP,
    input  logic [CNT_W-1:0]  spiCNT,
    input  logic [DATA_W-1:0] spiTXD,
    output logic              spiTXACK,
    output logic [DATA_W-1:0] spiRXD,
    output logic              spiRXV,
    output logic              spiDONE,
    output logic              spiBUSY,
`ifdef SDSPI_CRC16_EN
    output logic [15:0]       spiCRC,
`endif
    output logic              spiCS,
    output logic              spiSCLK,
    output logic              spiMOSI,
    input  logic              spiMISO
);
    localparam int BIT_W = $clog2(DATA_W);

    state_t             state;
    logic               fast;
    logic [DATA_W-1:0]  tx_sh;
    logic [DATA_W-1:0]  rx_sh;
    logic [BIT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   word_cnt;
    logic               start;
    logic               more_words;
    logic               div_load;
    logic               div_en;
    logic               div_tc;

    assign start      = (state == IDLE) && !spiBUSY && (spiOP == spiTR);
    assign more_words = (word_cnt > CNT_W'(1));

    // The divider reloads at every SCLK edge and whenever a new word begins.
    always_comb begin
        div_load = 1'b0;
        div_en   = 1'b0;
        case (state)
            IDLE:      div_load = start;
            LOW, HIGH: begin
                div_en   = 1'b1;
                div_load = div_tc;
            end
            WEND:      div_load = more_words;
            default:   ;
        endcase
    end

    sdspi_clkdiv #(
        .SLOW_DIV(SLOW_DIV),
        .FAST_DIV(FAST_DIV)
    ) u_clkdiv (
        .clk (clk),
        .rst (rst),
        .fast(fast),
        .load(div_load),
        .en  (div_en),
        .tc  (div_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fast     <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            spiCS    <= 1'b1;
            spiSCLK  <= 1'b0;
            spiMOSI  <= 1'b1;
            spiRXD   <= '0;
            spiTXACK <= 1'b0;
            spiRXV   <= 1'b0;
            spiDONE  <= 1'b0;
            spiBUSY  <= 1'b0;
`ifdef SDSPI_CRC16_EN
            spiCRC   <= '0;
`endif
        end else begin
            spiTXACK <= 1'b0;
            spiRXV   <= 1'b0;
            spiDONE  <= 1'b0;
            case (state)
                IDLE: begin
                    // Busy is still high on the spiDONE cycle, so ops are ignored there too.
                    spiBUSY <= 1'b0;
                    if (!spiBUSY) begin
                        case (spiOP)
                            spiCSL:  spiCS <= 1'b0;
                            spiCSH:  spiCS <= 1'b1;
                            spiSLOW: fast  <= 1'b0;
                            spiFAST: fast  <= 1'b1;
                            spiTR: begin
                                tx_sh    <= spiTXD;
                                spiMOSI  <= spiTXD[DATA_W-1];
                                bit_cnt  <= BIT_W'(DATA_W - 1);
                                word_cnt <= (spiCNT == '0) ? CNT_W'(1) : spiCNT;
                                spiTXACK <= 1'b1;
                                spiBUSY  <= 1'b1;
                                state    <= LOW;
                            end
`ifdef SDSPI_CRC16_EN
                            spiCRCCLR: spiCRC <= '0;
`endif
                            default: ;
                        endcase
                    end
                end
                LOW: begin
                    if (div_tc) begin
                        spiSCLK <= 1'b1;
                        rx_sh   <= {rx_sh[DATA_W-2:0], spiMISO};
`ifdef SDSPI_CRC16_EN
                        spiCRC  <= crc16_step(spiCRC, spiMOSI);
`endif
                        state   <= HIGH;
                    end
                end
                HIGH: begin
                    if (div_tc) begin
                        spiSCLK <= 1'b0;
                        if (bit_cnt != '0) begin
                            bit_cnt <= bit_cnt - 1'b1;
                            tx_sh   <= {tx_sh[DATA_W-2:0], 1'b0};
                            spiMOSI <= tx_sh[DATA_W-2];
                            state   <= LOW;
                        end else begin
                            state   <= WEND;
                        end
                    end
                end
                WEND: begin
                    spiRXD   <= rx_sh;
                    spiRXV   <= 1'b1;
                    word_cnt <= word_cnt - 1'b1;
                    if (more_words) begin
                        tx_sh    <= spiTXD;
                        spiMOSI  <= spiTXD[DATA_W-1];
                        bit_cnt  <= BIT_W'(DATA_W - 1);
                        spiTXACK <= 1'b1;
                        state    <= LOW;
                    end else begin
                        spiDONE  <= 1'b1;
                        spiMOSI  <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sdspi_burst.sv
// Self-checking bench for sdspi_burst: directed and randomized bursts against a transfer-level model.
// Defining SDSPI_CRC16_EN also exercises the CRC-16 output.
module tb_sdspi_burst;
    import sdspi_types::*;

    localparam int DW   = 8;
    localparam int SLOW = 100;
    localparam int FAST = 2;
    localparam int CW   = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    spiOP_t        spiOP = spiNOP;
    logic [CW-1:0] spiCNT = '0;
    logic [DW-1:0] spiTXD = '0;
    logic          spiTXACK;
    logic [DW-1:0] spiRXD;
    logic          spiRXV;
    logic          spiDONE;
    logic          spiBUSY;
    logic          spiCS;
    logic          spiSCLK;
    logic          spiMOSI;
    logic          spiMISO;
`ifdef SDSPI_CRC16_EN
    logic [15:0]   spiCRC;
`endif

    logic loopback = 1'b0;
    logic miso_bit = 1'b1;
    assign spiMISO = loopback ? spiMOSI : miso_bit;

    sdspi_burst #(
        .DATA_W(DW),
        .SLOW_DIV(SLOW),
        .FAST_DIV(FAST),
        .CNT_W(CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .spiOP   (spiOP),
        .spiCNT  (spiCNT),
        .spiTXD  (spiTXD),
        .spiTXACK(spiTXACK),
        .spiRXD  (spiRXD),
        .spiRXV  (spiRXV),
        .spiDONE (spiDONE),
        .spiBUSY (spiBUSY),
`ifdef SDSPI_CRC16_EN
        .spiCRC  (spiCRC),
`endif
        .spiCS   (spiCS),
        .spiSCLK (spiSCLK),
        .spiMOSI (spiMOSI),
        .spiMISO (spiMISO)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] exp_tx[$];
    logic [DW-1:0] exp_miso[$];
    logic [DW-1:0] tx_q[$];
    logic [DW-1:0] rx_q[$];
    logic          miso_q[$];
    logic          mosi_q[$];
    int            done_cnt, rxv_cnt, txack_cnt, busy_cyc, sclk_hi_cyc;
    logic          cs_seen_high;

    // Slave side: record MOSI on each rising SCLK, then advance to the next MISO bit.
    always @(posedge spiSCLK) begin
        mosi_q.push_back(spiMOSI);
        if (miso_q.size() > 0) void'(miso_q.pop_front());
        miso_bit = (miso_q.size() > 0) ? miso_q[0] : 1'b1;
    end

    // Caller side: watch the handshake pulses and feed the next TX word after each ack.
    always @(negedge clk) begin
        if (spiRXV) begin
            rxv_cnt++;
            rx_q.push_back(spiRXD);
        end
        if (spiDONE) done_cnt++;
        if (spiTXACK) begin
            txack_cnt++;
            if (tx_q.size() > 0) spiTXD = tx_q.pop_front();
        end
        if (spiBUSY) begin
            busy_cyc++;
            if (spiCS) cs_seen_high = 1'b1;
            if (spiSCLK) sclk_hi_cyc++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input spiOP_t op);
        @(negedge clk);
        spiOP = op;
        @(negedge clk);
        spiOP = spiNOP;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cs"},    32'(spiCS),    32'd1);
        checkOutput({tag, "_sclk"},  32'(spiSCLK),  32'd0);
        checkOutput({tag, "_mosi"},  32'(spiMOSI),  32'd1);
        checkOutput({tag, "_rxd"},   32'(spiRXD),   32'd0);
        checkOutput({tag, "_txack"}, 32'(spiTXACK), 32'd0);
        checkOutput({tag, "_rxv"},   32'(spiRXV),   32'd0);
        checkOutput({tag, "_done"},  32'(spiDONE),  32'd0);
        checkOutput({tag, "_busy"},  32'(spiBUSY),  32'd0);
    endtask

    task automatic randomWords(input int n);
        exp_tx.delete();
        exp_miso.delete();
        for (int i = 0; i < n; i++) begin
            exp_tx.push_back(DW'($urandom));
            exp_miso.push_back(DW'($urandom));
        end
    endtask

    task automatic startBurst(input int cnt);
        tx_q.delete();
        rx_q.delete();
        miso_q.delete();
        mosi_q.delete();
        done_cnt = 0; rxv_cnt = 0; txack_cnt = 0; busy_cyc = 0; sclk_hi_cyc = 0;
        cs_seen_high = 1'b0;
        spiTXD = exp_tx[0];
        for (int i = 1; i < exp_tx.size(); i++) tx_q.push_back(exp_tx[i]);
        for (int i = 0; i < exp_miso.size(); i++)
            for (int b = DW - 1; b >= 0; b--) miso_q.push_back(exp_miso[i][b]);
        miso_bit = (miso_q.size() > 0) ? miso_q[0] : 1'b1;
        spiCNT = CW'(cnt);
        applyStimulus(spiTR);
    endtask

    task automatic finishBurst(input int div, input string tag);
        int n;
        int word_len;
        int k;
        logic [DW-1:0] got;
        logic [DW-1:0] want;
        logic          b;
        n = exp_tx.size();
        word_len = 2 * div * DW + 1;
        k = 0;
        while (done_cnt == 0 && k < n * word_len + 20) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_finished"}, 32'(done_cnt != 0), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput({tag, "_done_count"},  32'(done_cnt),  32'd1);
        checkOutput({tag, "_rxv_count"},   32'(rxv_cnt),   32'(n));
        checkOutput({tag, "_txack_count"}, 32'(txack_cnt), 32'(n));
        checkOutput({tag, "_busy_cycles"}, 32'(busy_cyc),  32'(n * word_len + 1));
        checkOutput({tag, "_sclk_high"},   32'(sclk_hi_cyc), 32'(n * DW * div));
        checkOutput({tag, "_busy_end"},    32'(spiBUSY),   32'd0);
        for (int i = 0; i < n; i++) begin
            got  = (i < rx_q.size()) ? rx_q[i] : 'x;
            want = loopback ? exp_tx[i] : exp_miso[i];
            checkOutput($sformatf("%s_rx%0d", tag, i), 32'(got), 32'(want));
            got = '0;
            for (int j = 0; j < DW; j++) begin
                b = (i * DW + j < mosi_q.size()) ? mosi_q[i * DW + j] : 1'bx;
                got = {got[DW-2:0], b};
            end
            checkOutput($sformatf("%s_mosi%0d", tag, i), 32'(got), 32'(exp_tx[i]));
        end
    endtask

    initial begin
        int n;
        string digits;

        repeat (3) @(negedge clk);
        checkResetValues("reset");
        rst = 1'b1;
        @(negedge clk);
        checkResetValues("after_reset");

        // Default slow speed, one word.
        randomWords(1);
        exp_tx[0] = 8'hAA;
        startBurst(1);
        finishBurst(SLOW, "slow");

        // Fast loopback of 0x55 with CS low.
        applyStimulus(spiFAST);
        applyStimulus(spiCSL);
        checkOutput("csl", 32'(spiCS), 32'd0);
        loopback = 1'b1;
        exp_tx.delete(); exp_miso.delete();
        exp_tx.push_back(8'h55);
        startBurst(1);
        finishBurst(FAST, "loop");
        checkOutput("loop_cs_low", 32'(cs_seen_high), 32'd0);
        loopback = 1'b0;

        // Three-word burst with directed MISO data.
        exp_tx   = '{8'h01, 8'h02, 8'h03};
        exp_miso = '{8'hF0, 8'h0F, 8'hFF};
        startBurst(3);
        finishBurst(FAST, "burst3");

        // Randomized bursts.
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(2, 5);
            randomWords(n);
            startBurst(n);
            finishBurst(FAST, $sformatf("rand%0d", r));
        end

        // A count of zero moves exactly one word.
        randomWords(1);
        startBurst(0);
        finishBurst(FAST, "cnt0");

        // CS and speed ops during a burst must be ignored.
        randomWords(2);
        startBurst(2);
        repeat (5) @(negedge clk);
        applyStimulus(spiCSH);
        applyStimulus(spiSLOW);
        checkOutput("busy_cs_kept", 32'(spiCS), 32'd0);
        finishBurst(FAST, "busy_ops");
        randomWords(1);
        startBurst(1);
        finishBurst(FAST, "speed_kept");
        applyStimulus(spiCSH);
        checkOutput("csh_after", 32'(spiCS), 32'd1);

        // Asynchronous reset in the middle of a four-word burst.
        applyStimulus(spiCSL);
        randomWords(4);
        startBurst(4);
        repeat (40) @(negedge clk);
        #2 rst = 1'b0;
        #1 checkResetValues("midreset");
        repeat (3) @(negedge clk);
        checkOutput("midreset_no_done", 32'(done_cnt), 32'd0);
        rst = 1'b1;
        applyStimulus(spiFAST);
        randomWords(1);
        startBurst(1);
        finishBurst(FAST, "post_reset");

`ifdef SDSPI_CRC16_EN
        applyStimulus(spiCRCCLR);
        checkOutput("crc_clear", 32'(spiCRC), 32'd0);
        digits = "123456789";
        exp_tx.delete(); exp_miso.delete();
        for (int i = 0; i < 9; i++) begin
            exp_tx.push_back(DW'(digits[i]));
            exp_miso.push_back(8'h00);
        end
        startBurst(9);
        finishBurst(FAST, "crc");
        checkOutput("crc_value", 32'(spiCRC), 32'h31C3);
`else
        digits = "";
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
